// File: rtl/dec_seq_if.sv
// Handshake and address bus between the sweep controller and dec_addr_sequencer.
interface dec_seq_if #(parameter int AW = 4);
  logic          start;
  logic          stop;
  logic          dir;
  logic [AW-1:0] first;
  logic [AW-1:0] last;
  logic [AW-1:0] a;
  logic          valid;
  logic          busy;
  logic          done;

  modport master (output start, stop, dir, first, last, input a, valid, busy, done);
  modport slave  (input start, stop, dir, first, last, output a, valid, busy, done);
endinterface

// File: rtl/dec_addr_sequencer.sv
// Address sweeper feeding the 4-to-16 decoder: walks first..last up or down, DWELL cycles per address.
// Optional macro DEC_SEQ_WRAP_EN: restart at first after last instead of ending the sweep.
module dec_addr_sequencer #(
  parameter int AW    = 4,
  parameter int DWELL = 2
) (
  input logic      clk,
  input logic      rst,
  dec_seq_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [7:0] CNT_MAX = 8'(DWELL - 1);

  state_t        state, state_nx;
  logic [AW-1:0] a_q, a_nx;
  logic [AW-1:0] first_q, first_nx, last_q, last_nx;
  logic          dir_q, dir_nx;
  logic          valid_q, valid_nx, busy_q, busy_nx, done_q, done_nx;
  logic [7:0]    cnt_q, cnt_nx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      a_q     <= '0;
      first_q <= '0;
      last_q  <= '0;
      dir_q   <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state   <= state_nx;
      a_q     <= a_nx;
      first_q <= first_nx;
      last_q  <= last_nx;
      dir_q   <= dir_nx;
      valid_q <= valid_nx;
      busy_q  <= busy_nx;
      done_q  <= done_nx;
      cnt_q   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    a_nx     = a_q;
    first_nx = first_q;
    last_nx  = last_q;
    dir_nx   = dir_q;
    valid_nx = valid_q;
    busy_nx  = busy_q;
    done_nx  = 1'b0;
    cnt_nx   = cnt_q;
    case (state)
      IDLE: begin
        valid_nx = 1'b0;
        busy_nx  = 1'b0;
        cnt_nx   = '0;
        // stop wins over a simultaneous start
        if (bus.start && !bus.stop) begin
          first_nx = bus.first;
          last_nx  = bus.last;
          dir_nx   = bus.dir;
          a_nx     = bus.first;
          valid_nx = 1'b1;
          busy_nx  = 1'b1;
          state_nx = RUN;
        end
      end
      RUN: begin
        if (bus.stop) begin
          state_nx = IDLE;
          valid_nx = 1'b0;
          busy_nx  = 1'b0;
          cnt_nx   = '0;
        end else if (cnt_q == CNT_MAX) begin
          cnt_nx = '0;
          if (a_q == last_q) begin
`ifdef DEC_SEQ_WRAP_EN
            a_nx    = first_q;
            done_nx = 1'b1;
`else
            state_nx = DONE;
            valid_nx = 1'b0;
            busy_nx  = 1'b0;
            done_nx  = 1'b1;
`endif
          end else begin
            a_nx = dir_q ? a_q - AW'(1) : a_q + AW'(1);
          end
        end else begin
          cnt_nx = cnt_q + 8'd1;
        end
      end
      DONE: begin
        state_nx = IDLE;
        valid_nx = 1'b0;
        busy_nx  = 1'b0;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign bus.a     = a_q;
  assign bus.valid = valid_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
endmodule

// File: tb/tb_dec_addr_sequencer.sv
// Randomized bench for dec_addr_sequencer against a cycle-indexed sweep model.
module tb_dec_addr_sequencer;
  localparam int AW    = 4;
  localparam int DWELL = 2;
`ifdef DEC_SEQ_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  dec_seq_if #(.AW(AW)) bus ();

  dec_addr_sequencer #(.AW(AW), .DWELL(DWELL)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic int nvisit(input logic [AW-1:0] f, input logic [AW-1:0] l, input logic d);
    logic [AW-1:0] diff;
    diff = d ? f - l : l - f;
    return int'(diff) + 1;
  endfunction

  function automatic logic [AW-1:0] addr_at(input logic [AW-1:0] f, input logic d, input int i);
    logic [AW-1:0] off;
    off = AW'(i);
    return d ? f - off : f + off;
  endfunction

  // Expected outputs k cycles after the edge that accepted start.
  task automatic model(input int k, input logic [AW-1:0] f, input logic [AW-1:0] l, input logic d,
                       output logic [AW-1:0] ea, output logic ev, output logic eb, output logic ed);
    int period, idx;
    period = nvisit(f, l, d) * DWELL;
    if (WRAP) begin
      idx = k % period;
      ea = addr_at(f, d, idx / DWELL); ev = 1'b1; eb = 1'b1; ed = (k >= period) && (idx == 0);
    end else if (k < period) begin
      ea = addr_at(f, d, k / DWELL); ev = 1'b1; eb = 1'b1; ed = 1'b0;
    end else begin
      ea = l; ev = 1'b0; eb = 1'b0; ed = (k == period);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'b0; bus.stop = 1'b0; bus.dir = 1'b0; bus.first = '0; bus.last = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({bus.a, bus.valid, bus.busy, bus.done} !== {AW'(0), 3'b000}) begin
      failures++;
      $display("FAIL reset got a=%0d v=%0b b=%0b d=%0b exp a=0 v=0 b=0 d=0",
               bus.a, bus.valid, bus.busy, bus.done);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Full sweep, optionally with start/first/last/dir noise while running, then stop.
  task automatic test_sweep(input string nm, input logic [AW-1:0] f, input logic [AW-1:0] l,
                            input logic d, input bit noise);
    int period, ncyc;
    logic [AW-1:0] ea;
    logic ev, eb, ed;
    period = nvisit(f, l, d) * DWELL;
    ncyc = WRAP ? 2 * period + 2 : period + 2;
    bus.first = f; bus.last = l; bus.dir = d; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int k = 0; k < ncyc; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      model(k, f, l, d, ea, ev, eb, ed);
      checks++;
      if ({bus.a, bus.valid, bus.busy, bus.done} !== {ea, ev, eb, ed}) begin
        failures++;
        $display("FAIL %s k=%0d got a=%0d v=%0b b=%0b d=%0b exp a=%0d v=%0b b=%0b d=%0b",
                 nm, k, bus.a, bus.valid, bus.busy, bus.done, ea, ev, eb, ed);
      end
      if (noise) begin
        bus.first = AW'($urandom); bus.last = AW'($urandom); bus.dir = 1'($urandom);
        bus.start = (k <= period) ? 1'($urandom) : 1'b0;
      end
    end
    bus.start = 1'b0; bus.stop = 1'b1;
    @(posedge clk); #1;
    bus.stop = 1'b0;
    model(ncyc - 1, f, l, d, ea, ev, eb, ed);
    checks++;
    if ({bus.a, bus.valid, bus.busy, bus.done} !== {ea, 3'b000}) begin
      failures++;
      $display("FAIL %s_end got a=%0d v=%0b b=%0b d=%0b exp a=%0d v=0 b=0 d=0",
               nm, bus.a, bus.valid, bus.busy, bus.done, ea);
    end
  endtask

  // Abort after ks observed cycles; a must hold the address current at that point.
  task automatic test_stop(input string nm, input logic [AW-1:0] f, input logic [AW-1:0] l,
                           input logic d, input int ks);
    logic [AW-1:0] ea;
    logic ev, eb, ed;
    bus.first = f; bus.last = l; bus.dir = d; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int k = 1; k <= ks; k++) begin @(posedge clk); #1; end
    bus.stop = 1'b1;
    model(ks, f, l, d, ea, ev, eb, ed);
    for (int r = 0; r < 2; r++) begin
      @(posedge clk); #1;
      bus.stop = 1'b0;
      checks++;
      if ({bus.a, bus.valid, bus.busy, bus.done} !== {ea, 3'b000}) begin
        failures++;
        $display("FAIL %s r=%0d got a=%0d v=%0b b=%0b d=%0b exp a=%0d v=0 b=0 d=0",
                 nm, r, bus.a, bus.valid, bus.busy, bus.done, ea);
      end
    end
  endtask

  task automatic test_start_stop_idle();
    bus.first = 4'd7; bus.last = 4'd8; bus.dir = 1'b0;
    bus.start = 1'b1; bus.stop = 1'b1;
    for (int r = 0; r < 3; r++) begin
      @(posedge clk); #1;
      checks++;
      if ({bus.valid, bus.busy, bus.done} !== 3'b000) begin
        failures++;
        $display("FAIL start_stop_idle r=%0d got v=%0b b=%0b d=%0b exp v=0 b=0 d=0",
                 r, bus.valid, bus.busy, bus.done);
      end
    end
    bus.start = 1'b0; bus.stop = 1'b0;
  endtask

  task automatic test_async_reset();
    bus.first = 4'd5; bus.last = 4'd10; bus.dir = 1'b0; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    checks++;
    if ({bus.a, bus.valid, bus.busy, bus.done} !== {AW'(0), 3'b000}) begin
      failures++;
      $display("FAIL async_reset got a=%0d v=%0b b=%0b d=%0b exp a=0 v=0 b=0 d=0",
               bus.a, bus.valid, bus.busy, bus.done);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [AW-1:0] rf, rl;
    logic rd;
    test_reset();
    test_sweep("t1_up", 4'd0, 4'd3, 1'b0, 1'b0);
    test_sweep("t2_down_wrap", 4'd2, 4'd14, 1'b1, 1'b0);
    test_sweep("t4_single", 4'd9, 4'd9, 1'b0, 1'b0);
    test_sweep("wrap_up", 4'd14, 4'd1, 1'b0, 1'b0);
    test_sweep("full_down", 4'd15, 4'd0, 1'b1, 1'b0);
    test_stop("t3_stop", 4'd0, 4'd15, 1'b0, 2);
    test_start_stop_idle();
    for (int i = 0; i < 6; i++) begin
      rf = AW'($urandom); rl = AW'($urandom); rd = 1'($urandom);
      test_sweep("rand_noise", rf, rl, rd, 1'b1);
    end
    for (int i = 0; i < 4; i++) begin
      rf = AW'($urandom); rl = AW'($urandom); rd = 1'($urandom);
      test_stop("rand_stop", rf, rl, rd, int'($urandom_range(0, nvisit(rf, rl, rd) * DWELL - 1)));
    end
    test_async_reset();
    test_sweep("after_reset", 4'd3, 4'd5, 1'b0, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
